// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding for the countdown timer
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// rtl/countdown_timer_tick_prescaler.sv - free-running divider producing one tick per PRESCALE enabled cycles
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    // A single-cycle divider still needs a one-bit register to stay legal.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The wrap cycle is the tick; it is only meaningful while enabled.
    assign tick = enable && (cnt_q == LAST);

    // Clear wins over counting; a disabled counter holds its phase.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + ONE;
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable, pausable countdown timer with expiry pulse
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             done_q;
    logic             done_d;

    logic presc_enable;
    logic presc_clear;
    logic tick;

    // The prescaler only advances on RUN cycles that stay in RUN; a pausing
    // cycle leaves the phase untouched so resume continues mid-period.
    assign presc_enable = (state_q == RUN) && !load && !pause;
    assign presc_clear  = load || ((state_q == IDLE) && start);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (presc_enable),
        .clear  (presc_clear),
        .tick   (tick)
    );

    // Next-state, count and done decode; load overrides every state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
            count_d = load_value;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_q == '0) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick && (count_q != '0)) begin
                        count_d = count_q - ONE;
                        if (count_q == ONE) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM, count and done registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign busy  = (state_q == RUN) || (state_q == PAUSED);

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning count width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PRESCALE, default 16, meaning clk cycles per decrement tick (legal values >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port load, input, 1 bit, meaning load load_value into count.
REQ-006 The block SHALL have port load_value, input, WIDTH bits, meaning the start value for the countdown.
REQ-007 The block SHALL have port start, input, 1 bit, meaning start or resume the countdown.
REQ-008 The block SHALL have port pause, input, 1 bit, meaning freeze the countdown.
REQ-009 The block SHALL have port count, output reg, WIDTH bits, meaning the current remaining value.
REQ-010 The block SHALL have port busy, output, 1 bit, meaning high while the state is RUN or PAUSED.
REQ-011 The block SHALL have port done, output reg, 1 bit, meaning a one-cycle pulse on expiry.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, PAUSED and EXPIRED.
REQ-013 All inputs SHALL be sampled on the rising edge of clk; every registered effect SHALL be visible on the next cycle.
REQ-014 load SHALL have top priority in every state: it sets count to load_value, clears the prescaler and sets the state to IDLE, aborting any RUN or PAUSED.
REQ-015 In IDLE, start with count != 0 SHALL move the state to RUN and clear the prescaler.
REQ-016 In IDLE, start with count == 0 SHALL move the state directly to EXPIRED and pulse done on the next cycle.
REQ-017 In RUN, the prescaler SHALL count 0..PRESCALE-1 and wrap; the cycle on which it wraps is a tick.
REQ-018 A tick SHALL decrement count by 1; count SHALL never wrap below 0.
REQ-019 A tick with count == 1 SHALL set count to 0, move the state to EXPIRED and raise done, all in the same registered cycle.
REQ-020 With PRESCALE = 1, count SHALL decrement on every RUN cycle.
REQ-021 The first decrement after start SHALL be visible exactly PRESCALE cycles after the state enters RUN.
REQ-022 In RUN, pause SHALL move the state to PAUSED, hold count and hold the prescaler phase; start SHALL be ignored in RUN.
REQ-023 In PAUSED, start SHALL return the state to RUN and resume from the held prescaler phase.
REQ-024 In PAUSED, if start and pause are both asserted, start SHALL win.
REQ-025 pause SHALL be ignored outside RUN.
REQ-026 In EXPIRED, count SHALL hold 0 and start and pause SHALL be ignored; only load or reset leaves EXPIRED.
REQ-027 done SHALL be high for exactly one cycle per expiry and never while busy is high.
REQ-028 busy SHALL be decoded combinationally from the state register.

Reset
REQ-029 While reset is high, the block SHALL asynchronously force: state IDLE, count 0, prescaler 0, done 0, busy 0.
REQ-030 Reset asserted mid-RUN or mid-PAUSED SHALL discard the countdown without pulsing done.
REQ-031 After reset deasserts, the block SHALL wait in IDLE for load or start.

Structure
REQ-032 The state encodings (2-bit localparams IDLE=0, RUN=1, PAUSED=2, EXPIRED=3) SHALL reside in the shared package counter_pkg.
REQ-033 The prescaler SHALL be the sub-module tick_prescaler (clk, reset, enable, clear, tick), using a $clog2(PRESCALE)-bit counter.
REQ-034 The top level SHALL contain only the FSM, the count register and the done register.

Verification
REQ-035 Bench scenario, load and count down: WIDTH=4, PRESCALE=4; load 5, then start -> count steps 5,4,3,2,1,0 at 4-cycle intervals; done high for 1 cycle with count==0; busy falls in the same cycle.
REQ-036 Bench scenario, PRESCALE=1: load 3, then start -> count 3,2,1,0 on consecutive cycles; done pulses once.
REQ-037 Bench scenario, pause and resume: pause 2 cycles into a 4-cycle tick period, hold 10 cycles, then start -> count frozen during the pause; the next decrement arrives 2 cycles after resume.
REQ-038 Bench scenario, zero and expired: load 0, then start -> EXPIRED, done pulses once; a further start leaves done at 0 and count at 0.
REQ-039 Bench scenario, load priority: load 9 together with pause during RUN -> count reads 9, state IDLE, busy 0, no done pulse.
REQ-040 Bench scenario, reset mid-run: assert reset asynchronously between clock edges at count=3 -> count, busy and done go to 0 immediately, with no done pulse after release.
